// File: rtl/aibcr3_dcc_crsgrygen.sv
// DCC coarse-delay code generator: integrates PD up/down decisions into
// an 8-bit saturating code, published as Gray, with settle wait and lock.
module aibcr3_dcc_crsgrygen #(
    parameter int unsigned INIT_CODE  = 128,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned LOCK_REV   = 4
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        en,
    input  logic        freeze,
    input  logic        pd_vld,
    input  logic        pd_up,
    output logic [10:3] gry,
    output logic [7:0]  code_bin,
    output logic        locked,
    output logic        sat_hi,
    output logic        sat_lo,
    output logic        busy
);

    localparam logic [7:0] INIT8     = 8'(INIT_CODE);
    localparam logic [7:0] INIT_GRY  = INIT8 ^ (INIT8 >> 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] LOCK4     = 4'(LOCK_REV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       step_go;

    logic [7:0] code_nxt;
    logic [3:0] rev_cnt, rev_nxt;
    logic [3:0] same_cnt, same_nxt;
    logic       last_dir, dir_nxt;
    logic       have_dir, have_nxt;
    logic       lock_nxt;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= IDLE;
            cnt      <= '0;
            code_bin <= INIT8;
            gry      <= INIT_GRY;
            rev_cnt  <= '0;
            same_cnt <= '0;
            last_dir <= 1'b0;
            have_dir <= 1'b0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            code_bin <= code_nxt;
            gry      <= code_nxt ^ (code_nxt >> 1);
            rev_cnt  <= rev_nxt;
            same_cnt <= same_nxt;
            last_dir <= dir_nxt;
            have_dir <= have_nxt;
            locked   <= lock_nxt;
        end
    end

    // A saturated request still re-enters SETTLE, only the step is dropped.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_go   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LD;
                end
                SETTLE: begin
                    if (cnt == 8'd0) state_nxt = SAMPLE;
                    else             cnt_nxt   = cnt - 8'd1;
                end
                SAMPLE: begin
                    if (pd_vld && !freeze) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = SETTLE_LD;
                        step_go   = pd_up ? !sat_hi : !sat_lo;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        code_nxt = code_bin;
        rev_nxt  = rev_cnt;
        same_nxt = same_cnt;
        dir_nxt  = last_dir;
        have_nxt = have_dir;
        lock_nxt = locked;
        if (!en) begin
            rev_nxt  = '0;
            same_nxt = '0;
            have_nxt = 1'b0;
            lock_nxt = 1'b0;
        end else if (step_go) begin
            code_nxt = pd_up ? code_bin + 8'd1 : code_bin - 8'd1;
            if (have_dir) begin
                if (pd_up != last_dir) begin
                    rev_nxt  = (rev_cnt >= LOCK4) ? LOCK4 : rev_cnt + 4'd1;
                    same_nxt = '0;
                end else begin
                    rev_nxt  = '0;
                    same_nxt = (same_cnt >= LOCK4) ? LOCK4 : same_cnt + 4'd1;
                end
            end
            dir_nxt  = pd_up;
            have_nxt = 1'b1;
            if (rev_nxt == LOCK4)       lock_nxt = 1'b1;
            else if (same_nxt == LOCK4) lock_nxt = 1'b0;
        end
    end

    always_comb begin
        busy   = (state == SETTLE);
        sat_hi = (code_bin == 8'hFF);
        sat_lo = (code_bin == 8'h00);
    end

endmodule

// File: tb/tb_aibcr3_dcc_crsgrygen.sv
// Directed bench for the DCC coarse Gray code generator, three instances:
// mid-range, near top (254) and near bottom (1, driven with inverted pd_up).
module tb_aibcr3_dcc_crsgrygen;

    localparam int SETTLE_CYC = 8;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        en, freeze, pd_vld, pd_up;
    logic [10:3] gry, gry_hi, gry_lo;
    logic [7:0]  code_bin, code_hi, code_lo;
    logic        locked, sat_hi, sat_lo, busy;
    logic        lk_hi, sh_hi, sl_hi, bz_hi;
    logic        lk_lo, sh_lo, sl_lo, bz_lo;

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    aibcr3_dcc_crsgrygen #(
        .INIT_CODE(128), .SETTLE_CYC(SETTLE_CYC), .LOCK_REV(4)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .en(en), .freeze(freeze),
        .pd_vld(pd_vld), .pd_up(pd_up), .gry(gry),
        .code_bin(code_bin), .locked(locked), .sat_hi(sat_hi),
        .sat_lo(sat_lo), .busy(busy)
    );

    aibcr3_dcc_crsgrygen #(
        .INIT_CODE(254), .SETTLE_CYC(SETTLE_CYC), .LOCK_REV(4)
    ) u_hi (
        .CLK(CLK), .RSTb(RSTb), .en(en), .freeze(freeze),
        .pd_vld(pd_vld), .pd_up(pd_up), .gry(gry_hi),
        .code_bin(code_hi), .locked(lk_hi), .sat_hi(sh_hi),
        .sat_lo(sl_hi), .busy(bz_hi)
    );

    aibcr3_dcc_crsgrygen #(
        .INIT_CODE(1), .SETTLE_CYC(SETTLE_CYC), .LOCK_REV(4)
    ) u_lo (
        .CLK(CLK), .RSTb(RSTb), .en(en), .freeze(freeze),
        .pd_vld(pd_vld), .pd_up(!pd_up), .gry(gry_lo),
        .code_bin(code_lo), .locked(lk_lo), .sat_hi(sh_lo),
        .sat_lo(sl_lo), .busy(bz_lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Counts busy cycles; pd_vld held during settle is dropped after 3 cycles.
    task automatic wait_settle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            n++;
            if (n == 4) pd_vld = 1'b0;
            tick();
        end
        chk(tag, n, SETTLE_CYC);
    endtask

    task automatic step(input bit up, input int ec, input int eg,
                        input int ehi, input int elk, input bit hold,
                        input string tag);
        pd_up  = up;
        pd_vld = 1'b1;
        tick();
        pd_vld = hold;
        chk({tag, "_code"}, code_bin, ec);
        chk({tag, "_gry"}, gry, eg);
        chk({tag, "_lock"}, locked, elk);
        chk({tag, "_hi"}, code_hi, ehi);
        chk({tag, "_shi"}, sh_hi, (ehi == 255));
        chk({tag, "_lo"}, code_lo, 255 - ehi);
        chk({tag, "_slo"}, sl_lo, (ehi == 255));
        wait_settle({tag, "_busy"});
        chk({tag, "_held"}, code_bin, ec);
    endtask

    initial begin
        RSTb = 1'b0; en = 1'b0; freeze = 1'b0;
        pd_vld = 1'b0; pd_up = 1'b0;
        tick(); tick();
        chk("rst_gry", gry, 8'hC0);
        chk("rst_code", code_bin, 128);
        chk("rst_lock", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", {sat_hi, sat_lo}, 2'b00);
        chk("rst_hi_gry", gry_hi, 8'h81);
        chk("rst_lo_sat", {sh_lo, sl_lo}, 2'b00);
        RSTb = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        en = 1'b1;
        tick();
        chk("en_busy", busy, 1);
        wait_settle("first_settle");
        step(1, 129, 8'hC1, 255, 0, 1'b1, "up1");
        step(1, 130, 8'hC3, 255, 0, 1'b0, "up2");
        step(1, 131, 8'hC2, 255, 0, 1'b0, "up3");
        chk("hi_gry_sat", gry_hi, 8'h80);

        en = 1'b0;
        tick();
        chk("dis_busy", busy, 0);
        chk("dis_code", code_bin, 131);
        en = 1'b1;
        tick();
        wait_settle("re_settle");
        step(1, 132, 8'hC6, 255, 0, 1'b0, "alt1");
        step(0, 131, 8'hC2, 254, 0, 1'b0, "alt2");
        chk("hi_gry_254", gry_hi, 8'h81);
        step(1, 132, 8'hC6, 255, 0, 1'b0, "alt3");
        step(0, 131, 8'hC2, 254, 0, 1'b0, "alt4");
        step(1, 132, 8'hC6, 255, 1, 1'b0, "alt5");
        step(1, 133, 8'hC7, 255, 1, 1'b0, "same1");
        step(1, 134, 8'hC5, 255, 1, 1'b0, "same2");
        step(1, 135, 8'hC4, 255, 1, 1'b0, "same3");
        step(1, 136, 8'hCC, 255, 0, 1'b0, "same4");
        step(0, 135, 8'hC4, 254, 0, 1'b0, "rl1");
        step(1, 136, 8'hCC, 255, 0, 1'b0, "rl2");
        step(0, 135, 8'hC4, 254, 0, 1'b0, "rl3");
        step(1, 136, 8'hCC, 255, 1, 1'b0, "rl4");

        freeze = 1'b1; pd_vld = 1'b1; pd_up = 1'b1;
        tick();
        chk("frz_code", code_bin, 136);
        chk("frz_busy", busy, 0);
        tick();
        chk("frz_code2", code_bin, 136);
        chk("frz_lock", locked, 1);
        freeze = 1'b0; pd_vld = 1'b0;
        tick();
        chk("frz_rel_busy", busy, 0);

        en = 1'b0; pd_vld = 1'b1; pd_up = 1'b0;
        tick();
        pd_vld = 1'b0;
        chk("drop_code", code_bin, 136);
        chk("drop_busy", busy, 0);
        chk("drop_lock", locked, 0);

        en = 1'b1;
        tick(); tick(); tick();
        chk("mid_busy", busy, 1);
        RSTb = 1'b0;
        #1;
        chk("arst_code", code_bin, 128);
        chk("arst_gry", gry, 8'hC0);
        chk("arst_busy", busy, 0);
        chk("arst_hi", code_hi, 254);
        chk("arst_lo", code_lo, 1);
        tick();
        RSTb = 1'b1;

        begin
            logic [7:0] pg, pc;
            int d;
            pg = gry; pc = code_bin;
            for (int i = 0; i < 6000; i++) begin
                pd_vld = ($urandom_range(0, 1) == 1);
                pd_up  = ($urandom_range(0, 1) == 1);
                freeze = ($urandom_range(0, 7) == 0);
                en     = ($urandom_range(0, 199) != 0);
                tick();
                d = int'(code_bin) - int'(pc);
                chk("rnd_g2b", gry, b2g(code_bin));
                chk("rnd_g2b_hi", gry_hi, b2g(code_hi));
                chk("rnd_g2b_lo", gry_lo, b2g(code_lo));
                chk("rnd_gstep", ($countones(gry ^ pg) <= 1), 1);
                chk("rnd_bstep", (d >= -1 && d <= 1), 1);
                pg = gry; pc = code_bin;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
